alu_result_stage: RTL and testbench

Registered output stage directly downstream of the ALU add/subtract unit. Captures each add/sub result together with its carry and overflow, derives zero and negative flags, and buffers up to two results in a small FIFO behind a valid/ready handshake toward writeback. Decouples the combinational ALU from writeback stalls and keeps a running count of completed operations.

---
 rtl/alu_result_stage.sv | 124 ++++++++++++
 tb/tb_alu_result_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the ALU add/subtract unit.
// Captures each result with its carry/overflow, derives N and Z, and buffers
// up to two entries in a FIFO toward writeback behind a valid/ready handshake.
// Also counts accepted results (op_cnt, wraps).
// Optional feature macro: ALU_RES_STICKY_OVF_EN adds a sticky overflow flag
// (sticky_ovf) with its clear input (clr_sticky).

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module alu_result_stage #(
    parameter int DATA_W = `REG_WIDTH,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_cf,
    input  logic              in_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_flags,
    output logic [CNT_W-1:0]  op_cnt
`ifdef ALU_RES_STICKY_OVF_EN
    ,
    output logic              sticky_ovf,
    input  logic              clr_sticky
`endif
);

    // Occupancy doubles as the state: EMPTY, ONE or FULL.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DATA_W-1:0] data_mem [2];
    logic [3:0]        flag_mem [2];
    logic [3:0]        in_flags;
    logic              push;
    logic              pop;

    // Handshake depends on registered occupancy only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flags captured at push time, packed {N, Z, C, V}.
    assign in_flags = {in_data[DATA_W-1], (in_data == '0), in_cf, in_ovf};

    assign out_data  = data_mem[rd_ptr];
    assign out_flags = flag_mem[rd_ptr];

    // Next occupancy from the push/pop pair; simultaneous push and pop holds.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_next unassigned (no latch).
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Occupancy and the two 1-bit pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            count <= count_next;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Entry storage, written at the write pointer on every accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two entries are reset so the payload reads 0 straight after reset.
            for (int i = 0; i < 2; i++) begin
                data_mem[i] <= '0;
                flag_mem[i] <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= in_data;
            flag_mem[wr_ptr] <= in_flags;
        end
    end

    // Count of accepted results; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt <= '0;
        end else if (push) begin
            op_cnt <= op_cnt + 1'b1;
        end
    end

`ifdef ALU_RES_STICKY_OVF_EN
    // Sticky overflow: an overflowing push wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
        end else if (push && in_ovf) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (8-bit data, 16-bit counter).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.

module tb_alu_result_stage;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_cf;
    logic              in_ovf;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_flags;
    logic [CNT_W-1:0]  op_cnt;
`ifdef ALU_RES_STICKY_OVF_EN
    logic              sticky_ovf;
    logic              clr_sticky;
`endif

    int total = 0;
    int bad   = 0;

    alu_result_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cf     (in_cf),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .op_cnt    (op_cnt)
`ifdef ALU_RES_STICKY_OVF_EN
        ,
        .sticky_ovf(sticky_ovf),
        .clr_sticky(clr_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic cf, input logic ovf);
        in_valid = v;
        in_data  = d;
        in_cf    = cf;
        in_ovf   = ovf;
    endtask

    // Watchdog: the run is bounded by fixed loops, this only guards a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef ALU_RES_STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        #3;
        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_flags", 32'(out_flags), 32'h0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
`ifdef ALU_RES_STICKY_OVF_EN
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
`endif
        tick();
        rst = 1'b0;

        // Zero result with carry: flags {N,Z,C,V} = 0110, 1-cycle latency
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("zero_valid", 32'(out_valid), 32'd1);
        check("zero_data", 32'(out_data), 32'h00);
        check("zero_flags", 32'(out_flags), 32'b0110);
        check("zero_op_cnt", 32'(op_cnt), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("zero_popped", 32'(out_valid), 32'd0);

        // Fill with 7F then 80(ovf) under backpressure; third push ignored
        drive(1'b1, 8'h7F, 1'b0, 1'b0);
        tick();
        check("fill1_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 8'h80, 1'b0, 1'b1);
        tick();
        check("fill2_in_ready", 32'(in_ready), 32'd0);
        check("fill2_op_cnt", 32'(op_cnt), 32'd3);
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        tick();
        check("ignored_op_cnt", 32'(op_cnt), 32'd3);
        check("ignored_in_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("head1_data", 32'(out_data), 32'h7F);
        check("head1_flags", 32'(out_flags), 32'b0000);
        out_ready = 1'b1;
        tick();
        check("head2_valid", 32'(out_valid), 32'd1);
        check("head2_data", 32'(out_data), 32'h80);
        check("head2_flags", 32'(out_flags), 32'b1001);
        check("head2_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_op_cnt", 32'(op_cnt), 32'd3);

        // Streaming: one per cycle, occupancy stays at one
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(i), i[0], 1'b0);
            tick();
            check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
            check($sformatf("stream%0d_data", i), 32'(out_data), 32'(i));
            check($sformatf("stream%0d_flags", i), 32'(out_flags), {30'd0, i[0], 1'b0});
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("stream_end_valid", 32'(out_valid), 32'd0);
        check("stream_op_cnt", 32'(op_cnt), 32'd13);

        // Asynchronous reset between edges while full
        out_ready = 1'b0;
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hBB, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("prerst_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_op_cnt", 32'(op_cnt), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'h00);
        tick();
        rst = 1'b0;
        drive(1'b1, 8'h81, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("postrst_valid", 32'(out_valid), 32'd1);
        check("postrst_data", 32'(out_data), 32'h81);
        check("postrst_flags", 32'(out_flags), 32'b1010);
        check("postrst_op_cnt", 32'(op_cnt), 32'd1);
        out_ready = 1'b1;
        tick();
        check("postrst_popped", 32'(out_valid), 32'd0);

`ifdef ALU_RES_STICKY_OVF_EN
        // Sticky overflow set, hold, set-beats-clear, clear
        drive(1'b1, 8'h80, 1'b0, 1'b1);
        tick();
        check("sticky_set", 32'(sticky_ovf), 32'd1);
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        tick();
        check("sticky_hold", 32'(sticky_ovf), 32'd1);
        drive(1'b1, 8'h7F, 1'b0, 1'b1);
        clr_sticky = 1'b1;
        tick();
        check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        clr_sticky = 1'b0;
        check("sticky_cleared", 32'(sticky_ovf), 32'd0);
        check("sticky_op_cnt", 32'(op_cnt), 32'd5);
`endif

        // Counter wrap: restart from reset, 65535 pushes then one more
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wrap_start_op_cnt", 32'(op_cnt), 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) tick();
        check("wrap_max_op_cnt", 32'(op_cnt), 32'hFFFF);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("wrap_zero_op_cnt", 32'(op_cnt), 32'd0);
        tick();
        check("wrap_hold_op_cnt", 32'(op_cnt), 32'd0);
        check("wrap_end_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
